// File: rtl/seq_div_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  function automatic int cnt_width(input int dvd_w);
    return $clog2(dvd_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DVD_W_DEF);

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring trial shift-subtract step: shift in the next dividend bit,
// subtract the divisor, keep the difference only when it does not borrow.
module div_step #(
  parameter int DVS_W = 4
) (
  input  logic [DVS_W-1:0] pr,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] pr_next,
  output logic             qbit
);

  logic [DVS_W:0] t;
  logic [DVS_W:0] d;

  always_comb begin
    t       = {pr, bit_in};
    d       = t - {1'b0, divisor};
    qbit    = ~d[DVS_W];
    // Either result is below the divisor here, so the top bit is always zero.
    pr_next = qbit ? d[DVS_W-1:0] : t[DVS_W-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first,
// with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, one quotient bit per cycle
// DONE  | results valid, done pulses for this one cycle
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
);

  localparam int CNT_W = cnt_width(DVD_W);

  state_t           state;
  state_t           state_next;
  logic [DVS_W-1:0] pr;
  logic [DVS_W-1:0] pr_next;
  logic [DVD_W-1:0] dividend_sr;
  logic [DVS_W-1:0] divisor_r;
  logic [CNT_W-1:0] cnt;
  logic             qbit;
  logic             accept;
  logic             div_zero;
  logic             last_step;

  div_step #(.DVS_W(DVS_W)) u_step (
    .pr      (pr),
    .bit_in  (dividend_sr[DVD_W-1]),
    .divisor (divisor_r),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  always_comb begin
    state_next = state;
    accept     = start && (state != RUN);
    div_zero   = (divisor == '0);
    last_step  = (state == RUN) && (cnt == CNT_W'(1));
    unique case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: begin
        if (accept) state_next = div_zero ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pr          <= '0;
      dividend_sr <= '0;
      divisor_r   <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      dbz         <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (div_zero) begin
          quotient  <= '1;
          remainder <= '0;
          dbz       <= 1'b1;
        end else begin
          dividend_sr <= dividend;
          divisor_r   <= divisor;
          pr          <= '0;
          cnt         <= CNT_W'(DVD_W);
        end
      end else if (state == RUN) begin
        dividend_sr <= {dividend_sr[DVD_W-2:0], qbit};
        pr          <= pr_next;
        cnt         <= cnt - CNT_W'(1);
        if (last_step) begin
          quotient  <= {dividend_sr[DVD_W-2:0], qbit};
          remainder <= pr_next;
          dbz       <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed table, handshake
// corner cases, reset mid-run and a shuffled sweep of all nonzero-divisor pairs.
module tb_seq_restoring_divider;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;

  seq_restoring_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Last result the bench expects the DUT to be holding.
  logic [DVD_W-1:0] hold_q;
  logic [DVS_W-1:0] hold_r;
  logic             hold_z;

  typedef struct {
    logic [DVD_W-1:0] a;
    logic [DVS_W-1:0] b;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    logic             z;
    int               lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drives one operation and watches it until done, sampling at negedges.
  task automatic run_op(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                        input bit b2b, input bit inject,
                        output int lat, output int bcnt, output int hold_ok, output int overlap);
    if (!b2b) @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start   = 1'b0;
    lat     = -1;
    bcnt    = 0;
    hold_ok = 1;
    overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) bcnt++;
      if (busy && done) overlap = 1;
      if (busy && (quotient !== hold_q || remainder !== hold_r || dbz !== hold_z)) hold_ok = 0;
      if (done) begin
        lat = c;
        break;
      end
      if (inject && (c == 3 || c == 5)) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_check(input string name, input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                          input bit b2b, input bit inject,
                          input logic [DVD_W-1:0] eq, input logic [DVS_W-1:0] er,
                          input logic ez, input int elat);
    int lat, bcnt, hold_ok, overlap;
    run_op(a, b, b2b, inject, lat, bcnt, hold_ok, overlap);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy_cycles"}, bcnt, ez ? 0 : DVD_W);
    chk({name, " busy_done_overlap"}, overlap, 0);
    chk({name, " hold_during_run"}, hold_ok, 1);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " dbz"}, dbz, ez);
    if (!ez)
      chk({name, " invariant"},
          (int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b), 1);
    hold_q = eq;
    hold_r = er;
    hold_z = ez;
  endtask

  int pairs[$];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    hold_q   = '0;
    hold_r   = '0;
    hold_z   = 1'b0;

    vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  z: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  z: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0,  z: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd15,  b: 4'd15, q: 8'd1,   r: 4'd0,  z: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd14,  b: 4'd15, q: 8'd0,   r: 4'd14, z: 1'b0, lat: 9};
    vecs[5] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd0,  z: 1'b1, lat: 1};
    vecs[6] = '{a: 8'd100, b: 4'd3,  q: 8'd33,  r: 4'd1,  z: 1'b0, lat: 9};

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", dbz, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, 1'b0,
               vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);

    // start pulses during RUN are ignored; start in the DONE cycle is accepted
    do_check("ignore_start", 8'd200, 4'd7, 1'b0, 1'b1, 8'd28, 4'd4, 1'b0, 9);
    do_check("b2b_from_done", 8'd50, 4'd9, 1'b1, 1'b0, 8'd5, 4'd5, 1'b0, 9);

    // reset in cycle 4 of RUN
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst dbz", dbz, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    hold_q = '0;
    hold_r = '0;
    hold_z = 1'b0;
    @(negedge clk);
    chk("rst stays idle", {busy, done}, 0);
    do_check("after_rst", 8'd81, 4'd9, 1'b0, 1'b0, 8'd9, 4'd0, 1'b0, 9);

    // every nonzero-divisor pair in shuffled order, checked against plain / and %
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        pairs.push_back(a * 16 + b);
    for (int i = pairs.size() - 1; i > 0; i--) begin
      int j, tmp;
      j        = $urandom_range(i, 0);
      tmp      = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = tmp;
    end
    foreach (pairs[k]) begin
      int a, b;
      a = pairs[k] / 16;
      b = pairs[k] % 16;
      do_check("sweep", 8'(a), 4'(b), 1'($urandom_range(1, 0)), 1'b0,
               8'(a / b), 4'(a % b), 1'b0, 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
